// File: rtl/instruction_fetch_if.sv
// Purpose: board/core-facing signal bundle of the instruction fetch stage.
// Signals:
//   btn_left_raw, btn_right_raw  raw push-buttons (into fetch)
//   sw_instr [INSTR_W]           switch word to be stored (into fetch)
//   PC [PC_W]                    core program counter (into fetch)
//   instruction [INSTR_W]        store word presented to core (out of fetch)
//   left_button, right_button    one-cycle debounced pulses (out of fetch)
//   cpu_reset                    core reset (out of fetch)
//   load_addr [PC_W]             next store slot to be written (out of fetch)
//   loading                      high while in LOAD mode (out of fetch)
// Modports: master = fetch stage, slave = board/core side.
interface instruction_fetch_if #(
   parameter int unsigned INSTR_W = 12,
   parameter int unsigned PC_W    = 3
);
   logic               btn_left_raw;
   logic               btn_right_raw;
   logic [INSTR_W-1:0] sw_instr;
   logic [PC_W-1:0]    PC;
   logic [INSTR_W-1:0] instruction;
   logic               left_button;
   logic               right_button;
   logic               cpu_reset;
   logic [PC_W-1:0]    load_addr;
   logic               loading;

   modport master (
      input  btn_left_raw, btn_right_raw, sw_instr, PC,
      output instruction, left_button, right_button, cpu_reset, load_addr, loading
   );

   modport slave (
      output btn_left_raw, btn_right_raw, sw_instr, PC,
      input  instruction, left_button, right_button, cpu_reset, load_addr, loading
   );
endinterface

// File: rtl/instruction_fetch.sv
// Purpose: upstream stage of the 3-bit-PC core. Debounces the left/right buttons into
//   one-cycle pulses, fills an 2**PC_W x INSTR_W store from the switches in LOAD mode and
//   serves instruction = mem[PC] to the core in RUN mode, holding the core in reset while
//   loading.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset
//   bus    instruction_fetch_if.master (buttons, switches, PC in; instruction, pulses,
//          cpu_reset, load_addr, loading out)
// Build option: define IFETCH_READBACK_EN to present mem[load_addr] on instruction during
//   LOAD (otherwise zero is presented while loading).
module instruction_fetch #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned INSTR_W         = 12,
   parameter int unsigned PC_W            = 3
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus
);

   localparam int unsigned     DEPTH     = 1 << PC_W;
   localparam int unsigned     CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [PC_W-1:0] ADDR_LAST = PC_W'(DEPTH - 1);

   typedef enum logic {ST_LOAD, ST_RUN} state_e;

   // Button index 0 = left, 1 = right
   logic [1:0]         raw;
   logic [1:0]         sync1_q;
   logic [1:0]         sync2_q;
   logic [1:0]         stable_q;
   logic [1:0]         pulse_q;
   logic [CNT_W-1:0]   cnt_q [2];

   state_e             state_q;
   logic [PC_W-1:0]    load_addr_q;
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic               left_q;
   logic               right_q;
   logic               cpu_reset_q;
   logic               loading_q;
   logic               lp;
   logic               rp;

   assign raw = {bus.btn_right_raw, bus.btn_left_raw};
   assign lp  = pulse_q[0];
   assign rp  = pulse_q[1];

   // Debounce: stable level flips once the synced level has disagreed for
   // DEBOUNCE_CYCLES+1 consecutive samples; only a 0->1 flip emits a pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         pulse_q  <= '0;
         for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int unsigned i = 0; i < 2; i++) begin
            pulse_q[i] <= 1'b0;
            if (sync2_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               stable_q[i] <= sync2_q[i];
               pulse_q[i]  <= sync2_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= CNT_W'(cnt_q[i] + 1'b1);
            end
         end
      end
   end

   // LOAD/RUN control, store writes and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         load_addr_q <= '0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         loading_q   <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         left_q  <= 1'b0;
         right_q <= 1'b0;
         if (state_q == ST_LOAD) begin
            if (lp) begin
               // Left wins over a coincident right: leave without writing
               state_q     <= ST_RUN;
               cpu_reset_q <= 1'b0;
               loading_q   <= 1'b0;
            end else if (rp) begin
               mem_q[load_addr_q] <= bus.sw_instr;
               load_addr_q        <= PC_W'(load_addr_q + 1'b1);
               if (load_addr_q == ADDR_LAST) begin
                  state_q     <= ST_RUN;
                  cpu_reset_q <= 1'b0;
                  loading_q   <= 1'b0;
               end
            end
         end else begin
            if (lp && rp) begin
               // Chord returns to LOAD; store contents are kept
               state_q     <= ST_LOAD;
               load_addr_q <= '0;
               cpu_reset_q <= 1'b1;
               loading_q   <= 1'b1;
            end else begin
               left_q  <= lp;
               right_q <= rp;
            end
         end
      end
   end

   // Zero-latency store read toward the core
   always_comb begin
      bus.instruction = '0;
      if (state_q == ST_RUN) begin
         bus.instruction = mem_q[bus.PC];
      end else begin
`ifdef IFETCH_READBACK_EN
         bus.instruction = mem_q[load_addr_q];
`else
         bus.instruction = '0;
`endif
      end
   end

   assign bus.left_button  = left_q;
   assign bus.right_button = right_q;
   assign bus.cpu_reset    = cpu_reset_q;
   assign bus.load_addr    = load_addr_q;
   assign bus.loading      = loading_q;

endmodule
